seed_dispense_sequencer: RTL
============================

# seed_dispense_sequencer

Per-hole metering sequencer that sits directly downstream of the seed counter, and also closes the loop around it. On each hole request it:
- pulses the counter's `start_counting`
- opens the metering gate until the counter reports `target_reached` or a timeout expires
- lets in-flight seeds settle, then pulses `stop_counting`
- records the hole result

It reports per-hole status and cumulative statistics to the supervisor. It latches a fault on sensor error or on repeated short holes.

## Interface
Parameters:
- `DISPENSE_TIMEOUT_CYCLES`, default 25000000: max gate-open time per hole (0.5 s at 50 MHz); minimum 2.
- `SETTLE_CYCLES`, default 500000: gate-closed wait before stop, so falling seeds are still counted; minimum 1.
- `MAX_CONSEC_SHORT`, default 3: consecutive short holes that raise a fault; range 1..15.
- `TIMER_W`, default 32: timer width; must hold both cycle parameters.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `hole_request` input 1: one-cycle pulse, hole position reached.
- `target_reached` input 1: from the seed counter.
- `seed_count` input 8: from the seed counter.
- `sensor_error` input 1: from the seed counter.
- `fault_clear` input 1: one-cycle pulse from the supervisor.
- `start_counting` output 1: one-cycle pulse to the counter.
- `stop_counting` output 1: one-cycle pulse to the counter.
- `gate_open` output 1: metering gate drive.
- `busy` output 1: state is not IDLE.
- `hole_done` output 1: one-cycle pulse, hole finished.
- `hole_short` output 1: qualifies `hole_done`; target was not reached.
- `request_dropped` output 1: one-cycle pulse, request arrived while not IDLE.
- `last_hole_seeds` output 8: seed count captured at stop.
- `holes_ok` output 16: saturating count of good holes.
- `holes_short` output 16: saturating count of short holes.
- `fault` output 1: latched fault.
- `fault_code` output 2: 00 none, 01 sensor, 10 consecutive short.
- `state` output 3: encoded FSM state, for debug.

## Operation
- FSM states: IDLE, ARM, DISPENSE, SETTLE, CLOSE, FAULT.
- IDLE: on `hole_request` go to ARM; if `fault` is set, stay and pulse `request_dropped`.
- ARM (1 cycle):
  - `start_counting`=1.
  - Load the timer with `DISPENSE_TIMEOUT_CYCLES`.
  - Go to DISPENSE.
- DISPENSE:
  - `gate_open`=1 and the timer decrements.
  - `target_reached` is ignored in the first DISPENSE cycle (blanking of the counter's stale value).
  - Priority order:
    1. `sensor_error` → FAULT, code 01.
    2. `target_reached` → SETTLE, short=0.
    3. timer reaches 0 → SETTLE, short=1.
- SETTLE:
  - `gate_open`=0.
  - Timer loaded with `SETTLE_CYCLES` on entry; on expiry go to CLOSE.
  - `sensor_error` → FAULT, code 01.
- CLOSE (1 cycle):
  - `stop_counting`=1, `hole_done`=1, `hole_short`=short.
  - `last_hole_seeds`←`seed_count`.
  - If short: `holes_short`++ and the consecutive-short counter (4 bit) ++; otherwise `holes_ok`++ and consecutive-short counter ←0.
  - If the consecutive-short count reaches `MAX_CONSEC_SHORT`: FAULT, code 10. Otherwise IDLE.
- FAULT:
  - On entry from DISPENSE or SETTLE, `stop_counting` pulses for 1 cycle and `gate_open`=0.
  - No `hole_done` pulse; statistics are unchanged.
  - `fault`=1 until `fault_clear`.
  - `fault_clear` → IDLE: clears `fault`, `fault_code` and the consecutive-short counter.
- `hole_request` while not IDLE (including FAULT): request ignored, `request_dropped` pulses.
- `fault_clear` in any state other than FAULT: ignored.
- `fault_clear` and `hole_request` in the same cycle in FAULT: the clear takes effect; the request is dropped (pulse).
- All 16-bit counters saturate at 0xFFFF.

## Timing
- All outputs are registered.
- Reset values:
  - Every 1-bit output is 0.
  - Counters, `last_hole_seeds` and `fault_code` are 0.
  - `state` is IDLE.
- Reset mid-operation: `gate_open` drops the cycle after `rst` is sampled high; no `stop_counting` is issued.
- Latency from `hole_request` sampled in cycle N:
  - `start_counting` high in N+1.
  - `gate_open` high from N+2.
  - `target_reached` is honoured from N+3.
- Full-length hole: gate open for exactly `DISPENSE_TIMEOUT_CYCLES` cycles, including the blanking cycle.
- `target_reached` seen in cycle M: `gate_open` low in M+1.
- Settle: exactly `SETTLE_CYCLES` cycles.
- CLOSE: 1 cycle. `busy` is low the cycle after CLOSE, so the minimum request spacing is accepted at that point.

## Structure
- Package `seed_dispense_pkg`: state encoding and the `fault_code` constants 00, 01 and 10.
- Sub-module `dispense_timer`:
  - Loadable down-counter with `load`, `value`, `en` inputs and an `expired` output.
  - Width `TIMER_W`; shared by DISPENSE and SETTLE.
- Statistics counters are inline.

## Test plan
Bench parameters: `DISPENSE_TIMEOUT_CYCLES`=100, `SETTLE_CYCLES`=8, `MAX_CONSEC_SHORT`=3.

1. Normal hole:
   - Stimulus: request in cycle 0; `target_reached` raised in cycle 20 with `seed_count`=5.
   - Expected: start in cycle 1; gate high in cycles 2–20; `stop_counting` and `hole_done` in cycle 29; `last_hole_seeds`=5, `holes_ok`=1, `hole_short`=0.
2. Stale target:
   - Stimulus: `target_reached` held high through ARM and the first DISPENSE cycle, then dropped, then raised in cycle 40.
   - Expected: gate stays open until cycle 40.
3. Timeout:
   - Stimulus: `target_reached` never raised.
   - Expected: gate high for exactly 100 cycles; `hole_short`=1; `holes_short`=1.
4. Three short holes back to back:
   - Expected: `fault`=1 with `fault_code`=10 after the third CLOSE.
   - Then a next request → `request_dropped`.
   - Then `fault_clear` → IDLE, and a new hole proceeds.
5. `sensor_error` in cycle 10 of DISPENSE:
   - Expected: gate low in the next cycle; one `stop_counting` pulse; `fault_code`=01; no `hole_done`; counters unchanged.
6. Busy and reset:
   - Stimulus: request during SETTLE; then `rst` asserted during DISPENSE.
   - Expected: `request_dropped` pulse for the request; after reset, all outputs return to reset values in the next cycle.

Source files
------------

// File: rtl/seed_dispense_pkg.sv
// Shared state encoding, fault codes and helpers for the per-hole seed
// metering sequencer.
package seed_dispense_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_CLOSE    = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  localparam logic [1:0] FC_NONE         = 2'b00;
  localparam logic [1:0] FC_SENSOR       = 2'b01;
  localparam logic [1:0] FC_CONSEC_SHORT = 2'b10;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/seed_dispense_sequencer_timer.sv
// Loadable down-counter shared by the gate-open and settle phases.
// expired flags the cycle whose decrement brings the count to zero.
module dispense_timer #(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  input  logic               en,
  output logic               expired
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - TIMER_W'(1);
    end
  end

  // Looking one count ahead makes a phase last exactly `value` cycles.
  assign expired = (count_q <= TIMER_W'(1));

endmodule

// File: rtl/seed_dispense_sequencer.sv
// Per-hole metering sequencer: arms the seed counter, opens the gate until
// target or timeout, settles, stops the counter and keeps hole statistics.
module seed_dispense_sequencer
  import seed_dispense_pkg::*;
#(
  parameter int DISPENSE_TIMEOUT_CYCLES = 25000000,
  parameter int SETTLE_CYCLES           = 500000,
  parameter int MAX_CONSEC_SHORT        = 3,
  parameter int TIMER_W                 = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hole_request,
  input  logic        target_reached,
  input  logic [7:0]  seed_count,
  input  logic        sensor_error,
  input  logic        fault_clear,
  output logic        start_counting,
  output logic        stop_counting,
  output logic        gate_open,
  output logic        busy,
  output logic        hole_done,
  output logic        hole_short,
  output logic        request_dropped,
  output logic [7:0]  last_hole_seeds,
  output logic [15:0] holes_ok,
  output logic [15:0] holes_short,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [2:0]  state
);

  localparam logic [TIMER_W-1:0] DISP_T   = TIMER_W'(DISPENSE_TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] SETTLE_T = TIMER_W'(SETTLE_CYCLES);
  localparam logic [3:0]         MAX_C    = 4'(MAX_CONSEC_SHORT);

  state_e       state_q, state_d;
  logic         blank_q;
  logic         short_q, short_d;
  logic [3:0]   consec_q, consec_d;
  logic [15:0]  holes_ok_q, holes_ok_d;
  logic [15:0]  holes_short_q, holes_short_d;
  logic [7:0]   last_seeds_q, last_seeds_d;
  logic [1:0]   fault_code_q, fault_code_d;
  logic         start_q, start_d;
  logic         stop_q, stop_d;
  logic         gate_q, gate_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         hshort_q, hshort_d;
  logic         drop_q, drop_d;
  logic         fault_q, fault_d;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_en;
  logic               timer_expired;

  dispense_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .value   (timer_value),
    .en      (timer_en),
    .expired (timer_expired)
  );

  assign timer_en = (state_q == ST_DISPENSE) || (state_q == ST_SETTLE);

  always_comb begin
    state_d       = state_q;
    short_d       = short_q;
    consec_d      = consec_q;
    holes_ok_d    = holes_ok_q;
    holes_short_d = holes_short_q;
    last_seeds_d  = last_seeds_q;
    fault_code_d  = fault_code_q;
    timer_load    = 1'b0;
    timer_value   = DISP_T;

    case (state_q)
      ST_IDLE: begin
        if (hole_request && !fault_q) state_d = ST_ARM;
      end
      ST_ARM: begin
        timer_load = 1'b1;
        timer_value = DISP_T;
        state_d = ST_DISPENSE;
      end
      ST_DISPENSE: begin
        // blank_q masks a target_reached left over from the previous hole.
        if (sensor_error) begin
          state_d = ST_FAULT;
          fault_code_d = FC_SENSOR;
        end else if (target_reached && !blank_q) begin
          state_d = ST_SETTLE;
          short_d = 1'b0;
          timer_load = 1'b1;
          timer_value = SETTLE_T;
        end else if (timer_expired) begin
          state_d = ST_SETTLE;
          short_d = 1'b1;
          timer_load = 1'b1;
          timer_value = SETTLE_T;
        end
      end
      ST_SETTLE: begin
        if (sensor_error) begin
          state_d = ST_FAULT;
          fault_code_d = FC_SENSOR;
        end else if (timer_expired) begin
          state_d = ST_CLOSE;
        end
      end
      ST_CLOSE: begin
        last_seeds_d = seed_count;
        if (short_q) begin
          holes_short_d = sat_inc16(holes_short_q);
          consec_d = (consec_q == 4'hF) ? consec_q : consec_q + 4'd1;
        end else begin
          holes_ok_d = sat_inc16(holes_ok_q);
          consec_d = 4'd0;
        end
        if (consec_d >= MAX_C) begin
          state_d = ST_FAULT;
          fault_code_d = FC_CONSEC_SHORT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (fault_clear) begin
          state_d = ST_IDLE;
          fault_code_d = FC_NONE;
          consec_d = 4'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    start_d  = (state_d == ST_ARM);
    gate_d   = (state_d == ST_DISPENSE);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_CLOSE);
    hshort_d = (state_d == ST_CLOSE) && short_d;
    fault_d  = (state_d == ST_FAULT);
    stop_d   = (state_d == ST_CLOSE) ||
               ((state_d == ST_FAULT) &&
                ((state_q == ST_DISPENSE) || (state_q == ST_SETTLE)));
    drop_d   = hole_request && ((state_q != ST_IDLE) || fault_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      blank_q       <= 1'b0;
      short_q       <= 1'b0;
      consec_q      <= 4'd0;
      holes_ok_q    <= 16'd0;
      holes_short_q <= 16'd0;
      last_seeds_q  <= 8'd0;
      fault_code_q  <= FC_NONE;
      start_q       <= 1'b0;
      stop_q        <= 1'b0;
      gate_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      hshort_q      <= 1'b0;
      drop_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      blank_q       <= (state_q == ST_ARM);
      short_q       <= short_d;
      consec_q      <= consec_d;
      holes_ok_q    <= holes_ok_d;
      holes_short_q <= holes_short_d;
      last_seeds_q  <= last_seeds_d;
      fault_code_q  <= fault_code_d;
      start_q       <= start_d;
      stop_q        <= stop_d;
      gate_q        <= gate_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      hshort_q      <= hshort_d;
      drop_q        <= drop_d;
      fault_q       <= fault_d;
    end
  end

  assign start_counting  = start_q;
  assign stop_counting   = stop_q;
  assign gate_open       = gate_q;
  assign busy            = busy_q;
  assign hole_done       = done_q;
  assign hole_short      = hshort_q;
  assign request_dropped = drop_q;
  assign last_hole_seeds = last_seeds_q;
  assign holes_ok        = holes_ok_q;
  assign holes_short     = holes_short_q;
  assign fault           = fault_q;
  assign fault_code      = fault_code_q;
  assign state           = state_q;

endmodule
